// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared constants, pixel record and address helper for the plot sink
// Revision: 1.0
// ============================================================================
package vga_pkg;

    localparam int H_RES     = 160;
    localparam int V_RES     = 120;
    localparam int FB_PIXELS = 19200;
    localparam int FB_AW     = 15;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sink_state_e;

    // y*160 + x without a multiplier; the largest on-screen result fits in 15 bits.
    function automatic logic [FB_AW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        logic [FB_AW-1:0] w_y;
        w_y = {8'd0, y};
        return (w_y << 7) + (w_y << 5) + {7'd0, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_plot_sink_if.sv
`default_nettype none
// ============================================================================
// vga_plot_sink_if : plot strobes, clear control, scan-out and framebuffer port
// Revision: 1.0
// ============================================================================
interface vga_plot_sink_if;
    import vga_pkg::*;

    logic             vga_plot;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             plot_ready;
    logic             overflow;
    logic             clear_start;
    logic [2:0]       clear_colour;
    logic             clear_done;
    logic             scan_req;
    logic [FB_AW-1:0] scan_addr;
    logic [2:0]       scan_rdata;
    logic             scan_valid;
    logic [FB_AW-1:0] fb_addr;
    logic             fb_we;
    logic [2:0]       fb_wdata;
    logic [2:0]       fb_rdata;

    modport master (
        output vga_plot, vga_x, vga_y, vga_colour, clear_start, clear_colour,
               scan_req, scan_addr, fb_rdata,
        input  plot_ready, overflow, clear_done, scan_rdata, scan_valid,
               fb_addr, fb_we, fb_wdata
    );

    modport slave (
        input  vga_plot, vga_x, vga_y, vga_colour, clear_start, clear_colour,
               scan_req, scan_addr, fb_rdata,
        output plot_ready, overflow, clear_done, scan_rdata, scan_valid,
               fb_addr, fb_we, fb_wdata
    );

endinterface
`default_nettype wire

// File: rtl/plot_fifo.sv
`default_nettype none
// ============================================================================
// plot_fifo : small synchronous FIFO of pixel records with flush
// Revision: 1.0
// ============================================================================
module plot_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   i_push,
    input  wire pixel_t i_data,
    input  wire logic   i_pop,
    input  wire logic   i_flush,
    output pixel_t      o_data,
    output logic        o_full,
    output logic        o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pixel_t        r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_wr_en;
    logic          w_rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr_en = i_push && !o_full && !i_flush;
    assign w_rd_en = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_plot_sink.sv
`default_nettype none
// ============================================================================
// vga_plot_sink : buffers plot strobes and writes them into the framebuffer,
//                 with scan-out priority and a clear-screen fill sequencer
// Revision: 1.0
// ============================================================================
module vga_plot_sink #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    vga_plot_sink_if.slave  bus
);

    import vga_pkg::*;

    localparam logic [7:0]       c_H_LIM   = 8'(H_RES);
    localparam logic [6:0]       c_V_LIM   = 7'(V_RES);
    localparam logic [FB_AW-1:0] c_FB_LAST = FB_AW'(H_RES * V_RES - 1);

    sink_state_e       r_state;
    sink_state_e       w_state_nxt;

    logic [FB_AW-1:0]  r_cnt;
    logic [2:0]        r_clr_col;
    logic              r_overflow;
    logic              r_done;
    logic              r_scan_d1;
    logic              r_scan_valid;
    logic [2:0]        r_scan_rdata;
    logic [FB_AW-1:0]  r_fb_addr;
    logic              r_fb_we;
    logic [2:0]        r_fb_wdata;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    pixel_t            w_head;
    pixel_t            w_push_data;
    logic              w_plot_ready;
    logic              w_clear_acc;
    logic              w_onscreen;
    logic              w_push;
    logic              w_last;
    logic              w_do_scan;
    logic              w_do_clr_wr;
    logic              w_do_pop;

    assign w_plot_ready = (r_state == IDLE) && !w_fifo_full;
    assign w_clear_acc  = (r_state == IDLE) && bus.clear_start;
    assign w_onscreen   = (bus.vga_x < c_H_LIM) && (bus.vga_y < c_V_LIM);
    assign w_push       = bus.vga_plot && w_plot_ready && w_onscreen && !w_clear_acc;
    assign w_last       = (r_cnt == c_FB_LAST);
    assign w_push_data  = '{x: bus.vga_x, y: bus.vga_y, colour: bus.vga_colour};

    plot_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_do_pop),
        .i_flush (w_clear_acc),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.clear_start)         w_state_nxt = CLEAR;
            CLEAR:   if (w_do_clr_wr && w_last)   w_state_nxt = IDLE;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    // Port arbitration: scan-out first, then the fill, then the plot FIFO.
    // A pop is suppressed on the clear_start edge because the flush discards it.
    always_comb begin
        w_do_scan   = bus.scan_req;
        w_do_clr_wr = 1'b0;
        w_do_pop    = 1'b0;
        if (!bus.scan_req) begin
            if (r_state == CLEAR) begin
                w_do_clr_wr = 1'b1;
            end else if (!w_fifo_empty && !w_clear_acc) begin
                w_do_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_addr    <= '0;
            r_fb_we      <= 1'b0;
            r_fb_wdata   <= '0;
            r_cnt        <= '0;
            r_clr_col    <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
            r_scan_d1    <= 1'b0;
            r_scan_valid <= 1'b0;
            r_scan_rdata <= '0;
        end else begin
            r_done       <= w_do_clr_wr && w_last;
            r_scan_d1    <= bus.scan_req;
            r_scan_valid <= r_scan_d1;
            if (r_scan_d1) begin
                r_scan_rdata <= bus.fb_rdata;
            end

            if (w_do_scan) begin
                r_fb_addr <= bus.scan_addr;
                r_fb_we   <= 1'b0;
            end else if (w_do_clr_wr) begin
                r_fb_addr  <= r_cnt;
                r_fb_we    <= 1'b1;
                r_fb_wdata <= r_clr_col;
            end else if (w_do_pop) begin
                r_fb_addr  <= pix_addr(w_head.x, w_head.y);
                r_fb_we    <= 1'b1;
                r_fb_wdata <= w_head.colour;
            end else begin
                r_fb_we <= 1'b0;
            end

            if (w_clear_acc) begin
                r_cnt     <= '0;
                r_clr_col <= bus.clear_colour;
            end else if (w_do_clr_wr) begin
                r_cnt <= r_cnt + FB_AW'(1);
            end

            if (w_clear_acc) begin
                r_overflow <= 1'b0;
            end else if (bus.vga_plot && !w_plot_ready && (r_state == IDLE)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.plot_ready = w_plot_ready;
    assign bus.overflow   = r_overflow;
    assign bus.clear_done = r_done;
    assign bus.scan_valid = r_scan_valid;
    assign bus.scan_rdata = r_scan_rdata;
    assign bus.fb_addr    = r_fb_addr;
    assign bus.fb_we      = r_fb_we;
    assign bus.fb_wdata   = r_fb_wdata;

endmodule
`default_nettype wire
